mem_access_unit: RTL and testbench

Data-memory stage of the 5-stage RISC-V pipeline: takes load/store requests from the EX/MEM register and performs byte/half/word accesses on an internal word-organised memory with configurable access latency. It drives the load result into the MEM/WB register's `data_i` and raises a stall to the hazard unit while an access is in flight. It handles sign/zero extension, byte-lane merging for sub-word stores, and misalignment/illegal-op detection.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_lane_align.sv | 58 +++++
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 tb/tb_mem_access_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory stage.
// Provides the RISC-V load/store funct3 encodings and the access FSM states.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane logic for the data-memory stage (purely combinational).
// Ports:
//   funct3_i  access size/sign
//   addr_lo_i byte offset within the word (addr[1:0])
//   wdata_i   raw store data (low byte/half used for sb/sh)
//   rword_i   word read from memory
//   be_o      store byte enables (bit i = byte lane i, little-endian)
//   wdata_o   store data replicated onto every candidate lane
//   rdata_o   selected load lane, sign- or zero-extended
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  // Store side: replicate data so the byte enables alone pick the lanes.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    unique case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
  end

  // Load side: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    byte_sh = rword_i >> {addr_lo_i, 3'b000};
    half_sh = rword_i >> {addr_lo_i[1], 4'b0000};
    unique case (funct3_i)
      F3_B:    rdata_o = {{24{byte_sh[7]}}, byte_sh[7:0]};
      F3_BU:   rdata_o = {24'd0, byte_sh[7:0]};
      F3_H:    rdata_o = {{16{half_sh[15]}}, half_sh[15:0]};
      F3_HU:   rdata_o = {16'd0, half_sh[15:0]};
      default: rdata_o = rword_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory stage: byte/half/word loads and stores on an internal
// word-organised memory with a fixed access latency.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   MemRead_i, MemWrite_i   load / store request from EX/MEM
//   funct3_i                access size and sign
//   addr_i                  byte address (upper bits alias)
//   data_i                  store data
//   data_o                  registered, extended load result
//   stall_o                 pipeline hold while an access is in flight
//   err_o                   illegal or misaligned request (combinational, IDLE only)
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  state_t        state;
  logic [CW-1:0] cnt;

  logic          lat_rd;
  logic          lat_wr;
  logic [2:0]    lat_f3;
  logic [AW+1:0] lat_addr;
  logic [31:0]   lat_data;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          req;
  logic          illegal;
  logic          misaligned;
  logic          accept;
  logic          commit;

  logic          cur_rd;
  logic          cur_wr;
  logic [2:0]    cur_f3;
  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_data;

  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic [31:0]   rword;

  logic          unused_addr;
  assign unused_addr = ^addr_i[31:AW+2];

  always_comb begin
    req        = MemRead_i | MemWrite_i;
    illegal    = (MemRead_i & MemWrite_i)
               | (MemRead_i  & !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
               | (MemWrite_i & !(funct3_i inside {F3_B, F3_H, F3_W}));
    misaligned = ((funct3_i inside {F3_H, F3_HU}) & addr_i[0])
               | ((funct3_i == F3_W) & (addr_i[1:0] != 2'b00));
    accept     = (state == IDLE) & req & !illegal & !misaligned;
  end

  // With LATENCY=1 the commit edge is the accept edge itself, before the
  // request has been latched, so the live inputs feed the datapath in IDLE.
  always_comb begin
    if (state == IDLE) begin
      cur_rd   = MemRead_i;
      cur_wr   = MemWrite_i;
      cur_f3   = funct3_i;
      cur_addr = addr_i[AW+1:0];
      cur_data = data_i;
    end else begin
      cur_rd   = lat_rd;
      cur_wr   = lat_wr;
      cur_f3   = lat_f3;
      cur_addr = lat_addr;
      cur_data = lat_data;
    end
  end

  // Edge entering DONE; reset wins so an aborted access leaves no trace.
  assign commit = !rst_i &
                  ((accept & (LATENCY == 1)) | ((state == BUSY) & (cnt == CW'(1))));

  assign stall_o = !rst_i & (accept | (state == BUSY));
  assign err_o   = !rst_i & (state == IDLE) & req & (illegal | misaligned);

  assign rword = mem[cur_addr[AW+1:2]];

  mem_lane_align u_align (
    .funct3_i  (cur_f3),
    .addr_lo_i (cur_addr[1:0]),
    .wdata_i   (cur_data),
    .rword_i   (rword),
    .be_o      (be),
    .wdata_o   (wdata),
    .rdata_o   (rdata)
  );

  always_ff @(posedge clk_i) begin
    if (commit && cur_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[cur_addr[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      data_o   <= '0;
      lat_rd   <= 1'b0;
      lat_wr   <= 1'b0;
      lat_f3   <= '0;
      lat_addr <= '0;
      lat_data <= '0;
    end else begin
      if (commit && cur_rd) data_o <= rdata;
      unique case (state)
        IDLE: begin
          if (accept) begin
            lat_rd   <= MemRead_i;
            lat_wr   <= MemWrite_i;
            lat_f3   <= funct3_i;
            lat_addr <= addr_i[AW+1:0];
            lat_data <= data_i;
            cnt      <= CW'(LATENCY - 1);
            state    <= (LATENCY == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, data_i;
  logic [31:0] data_o;
  logic        stall_o, err_o;

  logic        rd1, wr1;
  logic [2:0]  f31;
  logic [31:0] addr1, wdat1;
  logic [31:0] data1;
  logic        stall1, err1;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] mm [1024];
  logic [31:0] exp_data;
  logic        exp_stall, exp_err;

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .data_i(data_i),
    .data_o(data_o), .stall_o(stall_o), .err_o(err_o)
  );

  mem_access_unit #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .MemRead_i(rd1), .MemWrite_i(wr1),
    .funct3_i(f31), .addr_i(addr1), .data_i(wdat1),
    .data_o(data1), .stall_o(stall1), .err_o(err1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    check("stall", {31'd0, stall_o}, {31'd0, exp_stall});
    check("err",   {31'd0, err_o},   {31'd0, exp_err});
    check("data",  data_o, exp_data);
  end

  function automatic bit m_err(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a);
    if (!(rd || wr)) return 1'b0;
    if (rd && wr) return 1'b1;
    if (rd && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1'b1;
    if (wr && f3 > 2) return 1'b1;
    if ((f3 == 1 || f3 == 5) && (a % 2 != 0)) return 1'b1;
    if (f3 == 2 && (a % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3,
                                         input logic [31:0] a);
    int unsigned off = a % 4;
    logic [31:0] v = w >> (8 * off);
    if (f3 == 0 || f3 == 4) v = v % 256;
    if (f3 == 1 || f3 == 5) v = v % 65536;
    if (f3 == 0 && v >= 128)   v = v + 32'hFFFFFF00;
    if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] d);
    int unsigned off = a % 4;
    int unsigned size = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
    logic [31:0] r = w;
    for (int unsigned i = 0; i < size; i++) r[8*(off+i) +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  // Issue one request at posedge+1, run it to completion, update the model.
  task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        output int scnt, output bit eseen);
    int unsigned idx = (a / 4) % 1024;
    MemRead_i = rd; MemWrite_i = wr; funct3_i = f3; addr_i = a; data_i = d;
    scnt = 0; eseen = 1'b0;
    if (!(rd || wr) || m_err(rd, wr, f3, a)) begin
      exp_stall = 1'b0; exp_err = rd | wr;
      #2; scnt += int'(stall_o); eseen |= err_o;
      cycle();
    end else begin
      for (int unsigned k = 0; k < LAT; k++) begin
        exp_stall = 1'b1; exp_err = 1'b0;
        #2; scnt += int'(stall_o); eseen |= err_o;
        cycle();
      end
      if (wr) mm[idx] = m_store(mm[idx], f3, a, d);
      else    exp_data = m_load(mm[idx], f3, a);
      exp_stall = 1'b0; exp_err = 1'b0;
      #2; scnt += int'(stall_o); eseen |= err_o;
      cycle();
    end
    MemRead_i = 1'b0; MemWrite_i = 1'b0; funct3_i = '0; addr_i = '0; data_i = '0;
    exp_stall = 1'b0; exp_err = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    bit es;
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] a;

    rst_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; funct3_i = 3'b010;
    addr_i = 32'h10; data_i = '0;
    rd1 = 1'b0; wr1 = 1'b0; f31 = '0; addr1 = '0; wdat1 = '0;
    exp_data = '0; exp_stall = 1'b0; exp_err = 1'b0;
    #1;
    repeat (2) cycle();
    rst_i = 1'b0; MemRead_i = 1'b0;

    // Directed sequence
    do_req(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, sc, es);
    check("sw_stall_cycles", sc, 2);
    do_req(1, 0, 3'b010, 32'h10, 0, sc, es);
    check("lw_10", data_o, 32'hDEADBEEF);
    do_req(1, 0, 3'b000, 32'h13, 0, sc, es);
    check("lb_13", data_o, 32'hFFFFFFDE);
    do_req(1, 0, 3'b100, 32'h13, 0, sc, es);
    check("lbu_13", data_o, 32'h000000DE);
    do_req(1, 0, 3'b001, 32'h12, 0, sc, es);
    check("lh_12", data_o, 32'hFFFFDEAD);
    do_req(1, 0, 3'b101, 32'h10, 0, sc, es);
    check("lhu_10", data_o, 32'h0000BEEF);
    do_req(0, 1, 3'b000, 32'h11, 32'h0000007F, sc, es);
    do_req(1, 0, 3'b010, 32'h10, 0, sc, es);
    check("sb_then_lw", data_o, 32'hDEAD7FEF);
    do_req(0, 1, 3'b001, 32'h12, 32'h00001234, sc, es);
    do_req(1, 0, 3'b010, 32'h10, 0, sc, es);
    check("sh_then_lw", data_o, 32'h12347FEF);

    do_req(1, 0, 3'b010, 32'h12, 0, sc, es);
    check("lw_mis_err", {31'd0, es}, 1);
    check("lw_mis_stall", sc, 0);
    check("lw_mis_data", data_o, 32'h12347FEF);
    do_req(1, 1, 3'b010, 32'h10, 0, sc, es);
    check("rd_wr_err", {31'd0, es}, 1);
    do_req(0, 1, 3'b100, 32'h10, 32'h0, sc, es);
    check("sw_f3_100_err", {31'd0, es}, 1);
    do_req(1, 0, 3'b010, 32'h10, 0, sc, es);
    check("mem_unchanged", data_o, 32'h12347FEF);
    do_req(0, 0, 3'b010, 32'h10, 0, sc, es);
    check("alu_op_nostall", sc, 0);

    // Reset abort during BUSY
    do_req(0, 1, 3'b010, 32'h20, 32'hCAFEF00D, sc, es);
    MemWrite_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h20; data_i = 32'h12345678;
    exp_stall = 1'b1;
    cycle();
    rst_i = 1'b1; exp_stall = 1'b0;
    cycle();
    exp_data = '0;
    rst_i = 1'b0; MemWrite_i = 1'b0; addr_i = '0; data_i = '0; funct3_i = '0;
    cycle();
    do_req(1, 0, 3'b010, 32'h20, 0, sc, es);
    check("abort_lw_20", data_o, 32'hCAFEF00D);

    // Random phase over words 0..15 with aliased upper address bits
    for (int unsigned w = 0; w < 16; w++) do_req(0, 1, 3'b010, w * 4, $urandom, sc, es);
    for (int n = 0; n < 300; n++) begin
      int unsigned kind = $urandom_range(0, 9);
      rd = (kind < 5) || (kind == 9);
      wr = (kind >= 5 && kind < 9) || (kind == 9);
      if (kind == 8 && $urandom_range(0, 1) == 0) begin rd = 1'b0; wr = 1'b0; end
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = (rd && !wr) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 63)) | ($urandom << 12);
      do_req(rd, wr, f3, a, $urandom, sc, es);
    end

    // LATENCY=1 instance: store then two back-to-back loads
    wr1 = 1'b1; f31 = 3'b010; addr1 = 32'h40; wdat1 = 32'h11223344;
    #2; check("l1_sw_stall0", {31'd0, stall1}, 1);
    cycle();
    #2; check("l1_sw_stall1", {31'd0, stall1}, 0);
    cycle();
    wr1 = 1'b0; rd1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2; check("l1_lw_stall", {31'd0, stall1}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 1) check("l1_lw_data", data1, 32'h11223344);
      cycle();
    end
    rd1 = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
